// File: rtl/rr_arb_mux.sv
// N_CH:1 valid/ready arbiter-mux with one registered output stage.
// Round-robin or fixed-priority grant, with optional packet locking on in_last.
//
// state    | meaning
// UNLOCKED | free arbitration among all valid channels
// LOCKED   | mid-packet; only channel lk may be granted until its in_last beat
module rr_arb_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter bit RR    = 1'b1,
    parameter bit LOCK  = 1'b1,
    localparam int CW   = (N_CH <= 2) ? 1 : $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CW-1:0]         out_ch,
    input  logic                  out_ready
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [CW-1:0]    out_ch_q,    out_ch_d;
    logic [CW-1:0]    ptr_q,       ptr_d;
    logic [0:0]       lock_q,      lock_d;
    logic [CW-1:0]    lk_q,        lk_d;

    logic             load;
    logic [N_CH-1:0]  grant;
    logic [CW-1:0]    gnt_idx;
    logic             xfer;

    // rst_n gates load so no channel sees ready while reset is held
    assign load = rst_n && (!out_valid_q || out_ready);

    always_comb begin
        int idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_q == LOCKED) begin
            if (in_valid[lk_q]) grant[lk_q] = 1'b1;
        end else if (RR) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (!found && in_valid[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) gnt_idx = CW'(i);
        end
    end

    assign in_ready = grant & {N_CH{load}};
    assign xfer     = |in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_last_d = in_last[gnt_idx];
                out_ch_d   = gnt_idx;
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        lk_d   = lk_q;
        if (LOCK && xfer) begin
            if (lock_q == UNLOCKED && !in_last[gnt_idx]) begin
                lock_d = LOCKED;
                lk_d   = gnt_idx;
            end else if (lock_q == LOCKED && in_last[gnt_idx]) begin
                lock_d = UNLOCKED;
            end
        end
    end

    // Pointer advances past the winner only once its packet has ended
    always_comb begin
        ptr_d = ptr_q;
        if (RR && xfer && lock_d == UNLOCKED) begin
            if (gnt_idx == CW'(N_CH - 1)) ptr_d = '0;
            else                          ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
            lock_q      <= UNLOCKED;
            lk_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lk_q        <= lk_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin/lock instance, fixed-priority
// instance, and a 3-channel round-robin instance sharing one clock and reset.
module tb_rr_arb_mux;

    logic clk;
    logic rst_n;

    // Instance A: N_CH=4, RR=1, LOCK=1
    logic [3:0]   a_valid, a_last, a_ready;
    logic [127:0] a_data;
    logic         a_ovalid, a_olast, a_oready;
    logic [31:0]  a_odata;
    logic [1:0]   a_och;

    // Instance B: N_CH=4, RR=0, LOCK=1
    logic [3:0]   b_valid, b_last, b_ready;
    logic [127:0] b_data;
    logic         b_ovalid, b_olast, b_oready;
    logic [31:0]  b_odata;
    logic [1:0]   b_och;

    // Instance C: N_CH=3, RR=1, LOCK=1
    logic [2:0]   c_valid, c_last, c_ready;
    logic [95:0]  c_data;
    logic         c_ovalid, c_olast, c_oready;
    logic [31:0]  c_odata;
    logic [1:0]   c_och;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb_mux #(.N_CH(4), .WIDTH(32), .RR(1'b1), .LOCK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_data(a_data), .in_last(a_last), .in_ready(a_ready),
        .out_valid(a_ovalid), .out_data(a_odata), .out_last(a_olast), .out_ch(a_och),
        .out_ready(a_oready)
    );

    rr_arb_mux #(.N_CH(4), .WIDTH(32), .RR(1'b0), .LOCK(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_data(b_data), .in_last(b_last), .in_ready(b_ready),
        .out_valid(b_ovalid), .out_data(b_odata), .out_last(b_olast), .out_ch(b_och),
        .out_ready(b_oready)
    );

    rr_arb_mux #(.N_CH(3), .WIDTH(32), .RR(1'b1), .LOCK(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_valid), .in_data(c_data), .in_last(c_last), .in_ready(c_ready),
        .out_valid(c_ovalid), .out_data(c_odata), .out_last(c_olast), .out_ch(c_och),
        .out_ready(c_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 4'hF;
        a_last  = 4'hF;
        #1;
        n_checks++;
        if (a_ready !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ready: in_ready=%b expected 0000", a_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_ovalid !== 1'b0 || a_och !== 2'd0) begin
            n_errors++; $display("FAIL reset_out: out_valid=%b out_ch=%0d expected 0,0", a_ovalid, a_och);
        end
        n_checks++;
        if (a_ready !== 4'b0001) begin
            n_errors++; $display("FAIL first_grant: in_ready=%b expected 0001", a_ready);
        end
        step();
        n_checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'd0 || a_odata !== 32'hA0) begin
            n_errors++; $display("FAIL first_beat: v=%b ch=%0d data=%h expected 1,0,a0", a_ovalid, a_och, a_odata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (a_ovalid !== 1'b1 || a_och !== exp_ch[k] || a_odata !== (32'hA0 + 32'(exp_ch[k]))) begin
                n_errors++;
                $display("FAIL rr_seq[%0d]: v=%b ch=%0d data=%h expected 1,%0d,%h",
                         k, a_ovalid, a_och, a_odata, exp_ch[k], 32'hA0 + 32'(exp_ch[k]));
            end
        end
        a_valid = 4'h0;
        step();
        n_checks++;
        if (a_ovalid !== 1'b0 || a_och !== 2'd1 || a_odata !== 32'hA1) begin
            n_errors++; $display("FAIL rr_idle_hold: v=%b ch=%0d data=%h expected 0,1,a1", a_ovalid, a_och, a_odata);
        end
    endtask

    // Pointer is at 2 here; ch2 sends a 3-beat packet while ch0 stays valid
    task automatic test_lock();
        a_valid = 4'b0101;
        a_last  = 4'b0001;
        a_data[64 +: 32] = 32'hB1;
        #1;
        n_checks++;
        if (a_ready !== 4'b0100) begin
            n_errors++; $display("FAIL lock_first_grant: in_ready=%b expected 0100", a_ready);
        end
        step();
        n_checks++;
        if (a_och !== 2'd2 || a_odata !== 32'hB1 || a_olast !== 1'b0) begin
            n_errors++; $display("FAIL lock_beat1: ch=%0d data=%h last=%b expected 2,b1,0", a_och, a_odata, a_olast);
        end
        a_data[64 +: 32] = 32'hB2;
        #1;
        n_checks++;
        if (a_ready !== 4'b0100) begin
            n_errors++; $display("FAIL lock_hold_grant: in_ready=%b expected 0100", a_ready);
        end
        step();
        n_checks++;
        if (a_och !== 2'd2 || a_odata !== 32'hB2) begin
            n_errors++; $display("FAIL lock_beat2: ch=%0d data=%h expected 2,b2", a_och, a_odata);
        end
        a_valid = 4'b0001;
        #1;
        n_checks++;
        if (a_ready !== 4'b0000) begin
            n_errors++; $display("FAIL lock_gap_block: in_ready=%b expected 0000", a_ready);
        end
        step();
        n_checks++;
        if (a_ovalid !== 1'b0) begin
            n_errors++; $display("FAIL lock_gap_bubble: out_valid=%b expected 0", a_ovalid);
        end
        a_valid = 4'b0101;
        a_last  = 4'b0101;
        a_data[64 +: 32] = 32'hB3;
        step();
        n_checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'd2 || a_odata !== 32'hB3 || a_olast !== 1'b1) begin
            n_errors++; $display("FAIL lock_beat3: v=%b ch=%0d data=%h last=%b expected 1,2,b3,1",
                                 a_ovalid, a_och, a_odata, a_olast);
        end
        n_checks++;
        if (a_ready !== 4'b0001) begin
            n_errors++; $display("FAIL unlock_grant: in_ready=%b expected 0001", a_ready);
        end
        step();
        n_checks++;
        if (a_och !== 2'd0 || a_odata !== 32'hA0) begin
            n_errors++; $display("FAIL after_packet: ch=%0d data=%h expected 0,a0", a_och, a_odata);
        end
        a_valid = 4'h0;
        step();
    endtask

    // Pointer is at 1 here
    task automatic test_backpressure();
        a_valid = 4'b0010;
        a_last  = 4'b1111;
        a_data[32 +: 32] = 32'hC1;
        step();
        n_checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'd1 || a_odata !== 32'hC1) begin
            n_errors++; $display("FAIL bp_load: v=%b ch=%0d data=%h expected 1,1,c1", a_ovalid, a_och, a_odata);
        end
        a_oready = 1'b0;
        a_data[32 +: 32] = 32'hC2;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (a_ready !== 4'b0000) begin
                n_errors++; $display("FAIL bp_ready[%0d]: in_ready=%b expected 0000", k, a_ready);
            end
            step();
            n_checks++;
            if (a_ovalid !== 1'b1 || a_odata !== 32'hC1) begin
                n_errors++; $display("FAIL bp_stall[%0d]: v=%b data=%h expected 1,c1", k, a_ovalid, a_odata);
            end
        end
        a_oready = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 4'b0010) begin
            n_errors++; $display("FAIL bp_release_ready: in_ready=%b expected 0010", a_ready);
        end
        step();
        n_checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 32'hC2) begin
            n_errors++; $display("FAIL bp_no_bubble: v=%b data=%h expected 1,c2", a_ovalid, a_odata);
        end
        a_valid = 4'h0;
        step();
        n_checks++;
        if (a_ovalid !== 1'b0) begin
            n_errors++; $display("FAIL bp_drain: out_valid=%b expected 0", a_ovalid);
        end
    endtask

    task automatic test_fixed_priority();
        b_valid = 4'b1010;
        b_last  = 4'b1111;
        #1;
        n_checks++;
        if (b_ready !== 4'b0010) begin
            n_errors++; $display("FAIL fp_grant: in_ready=%b expected 0010", b_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (b_ovalid !== 1'b1 || b_och !== 2'd1 || b_odata !== 32'hE1) begin
                n_errors++; $display("FAIL fp_hold[%0d]: v=%b ch=%0d data=%h expected 1,1,e1", k, b_ovalid, b_och, b_odata);
            end
        end
        b_valid = 4'b1000;
        step();
        n_checks++;
        if (b_och !== 2'd3 || b_odata !== 32'hE3) begin
            n_errors++; $display("FAIL fp_ch3: ch=%0d data=%h expected 3,e3", b_och, b_odata);
        end
        b_valid = 4'h0;
        step();
    endtask

    task automatic test_wrap_and_reset();
        c_valid = 3'b100;
        c_last  = 3'b111;
        step();
        n_checks++;
        if (c_och !== 2'd2 || c_odata !== 32'hD2) begin
            n_errors++; $display("FAIL wrap_ch2: ch=%0d data=%h expected 2,d2", c_och, c_odata);
        end
        c_valid = 3'b111;
        #1;
        n_checks++;
        if (c_ready !== 3'b001) begin
            n_errors++; $display("FAIL wrap_ptr: in_ready=%b expected 001", c_ready);
        end
        step();
        n_checks++;
        if (c_och !== 2'd0) begin
            n_errors++; $display("FAIL wrap_ch0: ch=%0d expected 0", c_och);
        end
        c_valid = 3'b010;
        c_last  = 3'b000;
        step();
        n_checks++;
        if (c_och !== 2'd1 || c_olast !== 1'b0) begin
            n_errors++; $display("FAIL lock_ch1: ch=%0d last=%b expected 1,0", c_och, c_olast);
        end
        c_valid = 3'b001;
        #1;
        n_checks++;
        if (c_ready !== 3'b000) begin
            n_errors++; $display("FAIL locked_block: in_ready=%b expected 000", c_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (c_ovalid !== 1'b0 || c_och !== 2'd0) begin
            n_errors++; $display("FAIL mid_reset: v=%b ch=%0d expected 0,0", c_ovalid, c_och);
        end
        step();
        rst_n   = 1'b1;
        c_valid = 3'b011;
        #1;
        n_checks++;
        if (c_ready !== 3'b001) begin
            n_errors++; $display("FAIL post_reset_grant: in_ready=%b expected 001", c_ready);
        end
        step();
        n_checks++;
        if (c_ovalid !== 1'b1 || c_och !== 2'd0 || c_odata !== 32'hD0) begin
            n_errors++; $display("FAIL post_reset_beat: v=%b ch=%0d data=%h expected 1,0,d0", c_ovalid, c_och, c_odata);
        end
        c_valid = 3'b000;
    endtask

    initial begin
        rst_n    = 1'b0;
        a_valid  = '0; a_last = '0; a_oready = 1'b1;
        a_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b_valid  = '0; b_last = '0; b_oready = 1'b1;
        b_data   = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        c_valid  = '0; c_last = '0; c_oready = 1'b1;
        c_data   = {32'hD2, 32'hD1, 32'hD0};

        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_fixed_priority();
        test_wrap_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the combinational packed-vector N:1 mux.
- Selects among N_CH valid/ready input channels under internal arbitration instead of an external select.
- Provides one registered output stage.
- Used in front of shared datapath resources (memory port, writeback bus), where several requesters contend for one WIDTH-bit path.
- Supports round-robin or fixed-priority arbitration, plus optional multi-beat packet locking via in_last.

Parameters:
N_CH, 4, number of input channels (>=2, need not be a power of 2)
WIDTH, 32, data width per channel
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
LOCK, 1, 1 = grant held from the first beat to the in_last beat, 0 = in_last ignored for arbitration (still forwarded)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  N_CH  per-channel valid
in_data  input  N_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH]
in_last  input  N_CH  per-channel last-beat flag
in_ready  output  N_CH  per-channel ready (combinational)
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered data
out_last  output  1  registered last flag
out_ch  output  CW  index of the source channel; CW = max(1, clog2(N_CH))
out_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_last=0, out_ch=0, rr pointer ptr=0, lock state UNLOCKED, locked channel lk=0.
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant is combinational and one-hot or zero:
  - UNLOCKED, RR=1: first asserted in_valid searching from ptr upward, wrapping modulo N_CH.
  - UNLOCKED, RR=0: lowest asserted index.
  - LOCKED: grant = lk only if in_valid[lk]; otherwise no grant. Other channels are blocked even when valid.
- in_ready[i] = grant[i] && load. All other in_ready bits are 0. in_ready never depends on in_valid of the same channel except through grant.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data=in_data[g], out_last=in_last[g], out_ch=g, out_valid=1.
- If load && no transfer: out_valid<=0, and out_data/out_last/out_ch hold their previous values.
- If !load: all output registers hold, and no input is accepted (stall).
- Latency: 1 cycle from input transfer to out_valid. With out_ready held at 1, throughput is 1 beat per cycle.
- Lock FSM (LOCK=1):
  - UNLOCKED -> LOCKED when a transfer occurs with in_last[g]=0; lk<=g.
  - LOCKED -> UNLOCKED on a transfer with in_last[lk]=1.
  - A single-beat packet (in_last=1 on the first beat) never enters LOCKED.
- LOCK=0: FSM permanently UNLOCKED.
- Pointer update (RR=1):
  - On a transfer that leaves the FSM UNLOCKED, ptr<=(g+1) mod N_CH. The wrap from N_CH-1 goes to 0, also for non-power-of-2 N_CH.
  - No update while LOCKED or without a transfer.
  - RR=0: ptr is unused.
- Simultaneous events: a new beat may be loaded in the same cycle the old one is consumed (out_valid && out_ready && transfer), with no bubble.
- Reset mid-packet: lock and ptr clear immediately. The partial packet downstream is not repaired; that is the responsibility of the source and sink.
- in_data/in_last of non-granted channels have no effect on any state.

Test Plan:
1. Reset with all in_valid=1 -> in_ready=0 during reset. After release: out_valid=0, out_ch=0. First grant goes to ch0, and out_data=in_data[0] one cycle later.
2. RR=1, N_CH=4, all channels valid single-beat, out_ready=1 -> out_ch sequence is 0,1,2,3,0,1 with one beat per cycle.
3. RR=0, ch1 and ch3 always valid -> out_ch stays 1. ch3 is never granted until ch1 drops valid.
4. LOCK=1: ch2 sends 3 beats (last on beat 3) while ch0 is valid throughout -> out_ch=2,2,2 then 0. Inserting an ch2 in_valid gap mid-packet produces an out_valid=0 bubble, with no ch0 grant.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable and all in_ready=0. out_ready=1 -> the next beat loads the same cycle, with no bubble.
6. N_CH=3, RR=1: a grant of ch2 wraps ptr to 0. Assert rst_n=0 while LOCKED on ch1 -> after release, FSM is UNLOCKED and ch0 wins.
